// File: rtl/pulse_sync.sv
// pulse_sync: brings an asynchronous event into the clk domain and emits one
// registered single-cycle pulse per detected event. TOGGLE_MODE=1 pulses on
// every transition of event_s; TOGGLE_MODE=0 pulses on rising edges only.
module pulse_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit TOGGLE_MODE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic event_s,
    output logic event_d,
    output logic level_d
);

    // Chain depths outside 2..4 are rejected when the design is elaborated.
    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
            $error("pulse_sync: SYNC_STAGES must be 2..4");
        end
    endgenerate

    // Bare flop-to-flop chain; the attribute keeps placement tight and
    // stops retiming from inserting logic between the stages.
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

    logic prev_q;
    logic pulse_q;
    logic sync_last;
    logic edge_d;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Edge detect on the synchronized level against its previous value.
    always_comb begin
        edge_d = 1'b0;
        if (TOGGLE_MODE)
            edge_d = sync_last ^ prev_q;
        else
            edge_d = sync_last & ~prev_q;
    end

    // Synchronizer shift, history flop and pulse register; reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], event_s};
            prev_q  <= sync_last;
            pulse_q <= edge_d;
        end
    end

    assign event_d = pulse_q;
    assign level_d = sync_last;

endmodule

// File: tb/tb_pulse_sync.sv
// Bench for pulse_sync: three instances (toggle/2 stages, rising/2 stages,
// toggle/4 stages). Stimulus pushes the cycle at which each pulse must be
// visible; a negedge monitor pops and checks every pulse the DUTs present.
module tb_pulse_sync;

    logic clk;
    logic rst_v [3];
    logic es    [3];
    logic ev    [3];
    logic lv    [3];

    int cyc;
    int n_cmp;
    int n_fail;
    int exp_q [3][$];
    bit async_mode;
    int async_cnt;
    logic prev_ev0;

    pulse_sync #(.SYNC_STAGES(2), .TOGGLE_MODE(1'b1)) u_tog2 (
        .clk(clk), .rst(rst_v[0]), .event_s(es[0]), .event_d(ev[0]), .level_d(lv[0]));
    pulse_sync #(.SYNC_STAGES(2), .TOGGLE_MODE(1'b0)) u_rise2 (
        .clk(clk), .rst(rst_v[1]), .event_s(es[1]), .event_d(ev[1]), .level_d(lv[1]));
    pulse_sync #(.SYNC_STAGES(4), .TOGGLE_MODE(1'b1)) u_tog4 (
        .clk(clk), .rst(rst_v[2]), .event_s(es[2]), .event_d(ev[2]), .level_d(lv[2]));

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every pulse must match the head of its DUT's queue.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ev[i] === 1'b1) begin
                if (async_mode && i == 0) begin
                    async_cnt++;
                    n_cmp++;
                    if (prev_ev0 === 1'b1) begin
                        n_fail++;
                        $display("FAIL async_width dut0: pulse high on two cycles, cycle %0d", cyc);
                    end
                end else if (exp_q[i].size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_pulse dut%0d: pulse at cycle %0d, none expected", i, cyc);
                end else begin
                    int e;
                    e = exp_q[i].pop_front();
                    n_cmp++;
                    if (e != cyc) begin
                        n_fail++;
                        $display("FAIL pulse_cycle dut%0d: got cycle %0d expected %0d", i, cyc, e);
                    end
                end
            end else if (ev[i] !== 1'b0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL event_d_x dut%0d: value %b at cycle %0d", i, ev[i], cyc);
            end
            if (exp_q[i].size() > 0 && exp_q[i][0] < cyc) begin
                int e;
                e = exp_q[i].pop_front();
                n_cmp++;
                n_fail++;
                $display("FAIL missing_pulse dut%0d: none at cycle %0d expected 1", i, e);
            end
        end
        prev_ev0 <= ev[0];
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive a new level and, if it is an event, record its due cycle.
    task automatic drive(input int i, input logic v, input int stages, input bit expect_pulse);
        es[i] = v;
        if (expect_pulse) exp_q[i].push_back(cyc + stages + 1);
    endtask

    initial begin
        cyc = 0; n_cmp = 0; n_fail = 0;
        async_mode = 0; async_cnt = 0; prev_ev0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b1;
            es[i] = 1'b0;
        end

        // Reset held 3 cycles with event_s toggling: outputs stay 0.
        tick(1);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) es[i] = ~es[i];
            tick(1);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rst_event_d%0d", i), ev[i], 1'b0);
                chk($sformatf("rst_level_d%0d", i), lv[i], 1'b0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            es[i] = 1'b0;
            rst_v[i] = 1'b0;
        end
        tick(8);

        // Toggle mode, 2 stages: rise then fall ten cycles later.
        drive(0, 1'b1, 2, 1'b1);
        tick(1); chk("tog2_level_e1", lv[0], 1'b0);
        tick(1); chk("tog2_level_e2", lv[0], 1'b1);
        tick(8);
        drive(0, 1'b0, 2, 1'b1);
        tick(1); chk("tog2_level_f1", lv[0], 1'b1);
        tick(1); chk("tog2_level_f2", lv[0], 1'b0);
        tick(6);

        // Rising mode: 5 cycles high, only the rise produces a pulse.
        drive(1, 1'b1, 2, 1'b1);
        tick(5);
        drive(1, 1'b0, 2, 1'b0);
        tick(1); chk("rise_level_hold", lv[1], 1'b1);
        tick(1); chk("rise_level_low", lv[1], 1'b0);
        tick(8);

        // Four stages: single transition, then 20 spaced transitions.
        drive(2, 1'b1, 4, 1'b1);
        tick(3); chk("s4_level_e3", lv[2], 1'b0);
        tick(1); chk("s4_level_e4", lv[2], 1'b1);
        tick(4);
        for (int k = 0; k < 20; k++) begin
            drive(2, ~es[2], 4, 1'b1);
            tick(6 + int'($urandom_range(0, 3)));
        end
        tick(8);

        // Mid-flight reset on dut0: the in-flight rise is discarded.
        drive(0, 1'b1, 2, 1'b0);
        tick(1);
        rst_v[0] = 1'b1;
        tick(1); chk("mid_rst_event_d", ev[0], 1'b0);
                 chk("mid_rst_level_d", lv[0], 1'b0);
        tick(1); chk("mid_rst_level_d2", lv[0], 1'b0);
        // Release with event_s still 1: the chain re-syncs and pulses once.
        rst_v[0] = 1'b0;
        exp_q[0].push_back(cyc + 3);
        tick(1); chk("mid_resync_e1", lv[0], 1'b0);
        tick(1); chk("mid_resync_e2", lv[0], 1'b1);
        tick(8);

        // Unrelated slower source: 50 toggles every 46 time units (2.3 periods).
        async_mode = 1;
        async_cnt = 0;
        #1;
        for (int k = 0; k < 50; k++) begin
            #46 es[0] = ~es[0];
        end
        tick(10);
        n_cmp++;
        if (async_cnt != 50) begin
            n_fail++;
            $display("FAIL async_count: got %0d pulses expected 50", async_cnt);
        end
        async_mode = 0;
        tick(2);

        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (exp_q[i].size() != 0) begin
                n_fail++;
                $display("FAIL drain dut%0d: %0d pulses outstanding expected 0", i, exp_q[i].size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation bound reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
